// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU program sequencer.
// SEQ_SINGLE_STEP_EN adds the PAUSE state used by single-step mode.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CPU_RST = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
`ifdef SEQ_SINGLE_STEP_EN
    ,
    ST_PAUSE   = 3'd5
`endif
  } seq_state_e;

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_ALU   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam int CLS_HI = 19;
  localparam int CLS_LO = 18;

  function automatic logic seq_is_busy(input seq_state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: synchronous write, combinational read.
module seq_prog_mem #(
  parameter int INSTR_WIDTH = 20,
  parameter int PROG_DEPTH  = 16,
  parameter int PC_BITS     = 4
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [PC_BITS-1:0]     i_waddr,
  input  logic [INSTR_WIDTH-1:0] i_wdata,
  input  logic [PC_BITS-1:0]     i_raddr,
  output logic [INSTR_WIDTH-1:0] o_rdata
);

  logic [INSTR_WIDTH-1:0] r_mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_instr_sequencer.sv
// Program sequencer: resets the CPU, then drives each stored instruction for a
// class-dependent number of cycles. Optional SEQ_SINGLE_STEP_EN adds step control.
module cpu_instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int INSTR_WIDTH = 20,
  parameter int PROG_DEPTH  = 16,
  parameter int PC_BITS     = 4,
  parameter int RST_CYCLES  = 2,
  parameter int ALU_HOLD    = 4,
  parameter int LOAD_HOLD   = 5,
  parameter int STORE_HOLD  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   prog_we,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic [PC_BITS:0]       prog_len,
  input  logic                   start,
  input  logic                   stop,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                   step_mode,
  input  logic                   step,
`endif
  output logic                   cpu_rst,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   done
);

  localparam int HW = 8;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [PC_BITS:0] DEPTH_L = (PC_BITS+1)'(PROG_DEPTH);

  seq_state_e             r_state, w_state_d;
  logic [PC_BITS:0]       r_len, w_len_d;
  logic [RW-1:0]          r_rst_cnt, w_rst_cnt_d;
  logic [HW-1:0]          r_hold, w_hold_d, w_hold_len;
  logic [PC_BITS-1:0]     r_pc, w_pc_d, w_raddr;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr_d, w_rdata;
  logic                   r_valid, w_valid_d;
  logic                   r_cpu_rst, w_cpu_rst_d;
  logic                   r_busy, w_busy_d;
  logic                   r_done, w_done_d;
  logic                   w_mem_we, w_last;
  logic                   w_abort, w_finish, w_expire, w_advance;

  assign w_mem_we = prog_we && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // Only one read is needed per cycle: entry 0 on leaving reset, else the next pc.
  assign w_raddr  = (r_state == ST_CPU_RST) ? '0 : r_pc + PC_BITS'(1);
  assign w_last   = ({1'b0, r_pc} == (r_len - (PC_BITS+1)'(1)));

  seq_prog_mem #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .PROG_DEPTH  (PROG_DEPTH),
    .PC_BITS     (PC_BITS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_hold_len = HW'(1);
    unique case (r_instr[CLS_HI:CLS_LO])
      CLS_ALU:   w_hold_len = HW'(ALU_HOLD);
      CLS_LOAD:  w_hold_len = HW'(LOAD_HOLD);
      CLS_STORE: w_hold_len = HW'(STORE_HOLD);
      CLS_NOP:   w_hold_len = HW'(1);
    endcase
  end

  always_comb begin
    w_state_d   = r_state;
    w_len_d     = r_len;
    w_rst_cnt_d = r_rst_cnt;
    w_hold_d    = r_hold;
    w_pc_d      = r_pc;
    w_instr_d   = r_instr;
    w_valid_d   = r_valid;
    w_cpu_rst_d = r_cpu_rst;
    w_done_d    = 1'b0;
    w_abort     = 1'b0;
    w_finish    = 1'b0;
    w_expire    = 1'b0;
    w_advance   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_d   = ST_CPU_RST;
          w_len_d     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
          w_rst_cnt_d = RW'(RST_CYCLES - 1);
          w_cpu_rst_d = 1'b1;
        end
      end
      ST_CPU_RST: begin
        if (stop) begin
          w_abort = 1'b1;
        end else if (r_rst_cnt == '0) begin
          w_cpu_rst_d = 1'b0;
          if (r_len == '0) begin
            w_finish = 1'b1;
          end else begin
            w_state_d = ST_ISSUE;
            w_pc_d    = '0;
            w_instr_d = w_rdata;
            w_valid_d = 1'b1;
          end
        end else begin
          w_rst_cnt_d = r_rst_cnt - RW'(1);
        end
      end
      // The ISSUE cycle is the first of the instruction's hold cycles.
      ST_ISSUE: begin
        if (stop) begin
          w_abort = 1'b1;
        end else if (w_hold_len <= HW'(1)) begin
          w_expire = 1'b1;
        end else begin
          w_hold_d  = w_hold_len - HW'(1);
          w_state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          w_abort = 1'b1;
        end else if (r_hold <= HW'(1)) begin
          w_expire = 1'b1;
        end else begin
          w_hold_d = r_hold - HW'(1);
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (stop) w_abort = 1'b1;
        else if (step) w_advance = 1'b1;
      end
`endif
      ST_DONE: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase

`ifdef SEQ_SINGLE_STEP_EN
    if (w_expire) begin
      if (step_mode) begin
        w_state_d = ST_PAUSE;
        w_valid_d = 1'b0;
      end else begin
        w_advance = 1'b1;
      end
    end
`else
    w_advance = w_expire;
`endif

    if (w_advance) begin
      if (w_last) begin
        w_finish = 1'b1;
      end else begin
        w_state_d = ST_ISSUE;
        w_pc_d    = r_pc + PC_BITS'(1);
        w_instr_d = w_rdata;
        w_valid_d = 1'b1;
      end
    end

    if (w_abort || w_finish) begin
      w_state_d   = ST_DONE;
      w_instr_d   = '0;
      w_valid_d   = 1'b0;
      w_cpu_rst_d = 1'b0;
      w_done_d    = 1'b1;
    end

    w_busy_d = seq_is_busy(w_state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_rst_cnt <= '0;
      r_hold    <= '0;
      r_pc      <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_cpu_rst <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_len     <= w_len_d;
      r_rst_cnt <= w_rst_cnt_d;
      r_hold    <= w_hold_d;
      r_pc      <= w_pc_d;
      r_instr   <= w_instr_d;
      r_valid   <= w_valid_d;
      r_cpu_rst <= w_cpu_rst_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  assign cpu_rst     = r_cpu_rst;
  assign instr_out   = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Self-checking bench: directed scenarios plus random programs, compared against
// a per-cycle trace built from the class/hold rules.
module tb_cpu_instr_sequencer;

  localparam int IW = 20;
  localparam int PD = 16;
  localparam int PB = 4;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [PB-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic [PB:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
`endif
  logic          cpu_rst, instr_valid, busy, done;
  logic [IW-1:0] instr_out;
  logic [PB-1:0] pc;

  cpu_instr_sequencer #(
    .INSTR_WIDTH (IW),
    .PROG_DEPTH  (PD),
    .PC_BITS     (PB),
    .RST_CYCLES  (RC),
    .ALU_HOLD    (4),
    .LOAD_HOLD   (5),
    .STORE_HOLD  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .start       (start),
    .stop        (stop),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .cpu_rst     (cpu_rst),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          c_rst;
    logic [IW-1:0] instr;
    logic          valid;
    logic [PB-1:0] pc;
    logic          busy;
    logic          done;
  } exp_t;

  int            tests = 0;
  int            fails = 0;
  logic [IW-1:0] mem_m [PD];
  int unsigned   pc_m = 0;
  exp_t          q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int hold_of(input logic [IW-1:0] ins);
    case (ins[19:18])
      2'b01:   return 4;
      2'b10:   return 5;
      2'b11:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic exp_t mk(input logic r, input logic [IW-1:0] ins, input logic v,
                              input int unsigned p, input logic b, input logic d);
    exp_t e;
    e.c_rst = r; e.instr = ins; e.valid = v; e.pc = PB'(p); e.busy = b; e.done = d;
    return e;
  endfunction

  // Expected outputs cycle by cycle, starting with the cycle after start is taken.
  task automatic build(input int unsigned plen, input int stop_at);
    int unsigned n;
    n = (plen > PD) ? PD : plen;
    q.delete();
    for (int i = 0; i < RC; i++) q.push_back(mk(1'b1, '0, 1'b0, pc_m, 1'b1, 1'b0));
    for (int unsigned i = 0; i < n; i++)
      for (int h = 0; h < hold_of(mem_m[i]); h++)
        q.push_back(mk(1'b0, mem_m[i], 1'b1, i, 1'b1, 1'b0));
    if (stop_at >= 0 && stop_at < q.size())
      while (q.size() > stop_at + 1) void'(q.pop_back());
    pc_m = q[$].pc;
    q.push_back(mk(1'b0, '0, 1'b0, pc_m, 1'b0, 1'b1));
    q.push_back(mk(1'b0, '0, 1'b0, pc_m, 1'b0, 1'b0));
  endtask

  task automatic write_mem(input int unsigned a, input logic [IW-1:0] d);
    prog_we = 1'b1; prog_addr = PB'(a); prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(e.c_rst));
    chk({tag, ".instr"}, 32'(instr_out), 32'(e.instr));
    chk({tag, ".valid"}, 32'(instr_valid), 32'(e.valid));
    chk({tag, ".pc"}, 32'(pc), 32'(e.pc));
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
    chk({tag, ".done"}, 32'(done), 32'(e.done));
  endtask

  task automatic run(input int unsigned plen, input int stop_at, input bit noise, input string tag);
    build(plen, stop_at);
    prog_len = (PB+1)'(plen);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      stop = (k == stop_at);
      if (noise && q[k].busy) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = PB'(1); prog_data = IW'($urandom);
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      check_outs($sformatf("%s[%0d]", tag, k), q[k]);
      @(posedge clk); #1;
    end
    stop = 1'b0; start = 1'b0; prog_we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t idle0;
    int   sa;

    // Reset asserted from time zero
    #2;
    idle0 = mk(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    check_outs("por", idle0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check_outs("post_rst", idle0);

    // Two ALU instructions
    write_mem(0, 20'h47000);
    write_mem(1, 20'h53000);
    run(2, -1, 1'b0, "alu2");

    // Mixed classes: ALU, STORE, LOAD
    write_mem(1, 20'hD80F0);
    write_mem(2, 20'hB80F0);
    run(3, -1, 1'b0, "mixed");

    // Abort in the 2nd hold cycle of instruction 1
    run(3, RC + hold_of(mem_m[0]) + 1, 1'b0, "abort");

    // Empty run
    run(0, -1, 1'b0, "empty");

    // Oversize run over a full random program
    for (int unsigned i = 0; i < PD; i++) write_mem(i, IW'($urandom));
    run(20, -1, 1'b0, "oversize");

    // Writes and restarts while busy are ignored; rerun proves mem[1] intact
    run(4, -1, 1'b1, "noise");
    run(4, -1, 1'b0, "after_noise");

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    idle0 = mk(1'b0, '0, 1'b0, pc_m, 1'b0, 1'b0);
    check_outs("startstop0", idle0);
    @(posedge clk); #1;
    check_outs("startstop1", idle0);

    // Random programs, lengths and abort points
    for (int r = 0; r < 8; r++) begin
      for (int unsigned i = 0; i < PD; i++) write_mem(i, IW'($urandom));
      sa = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 40));
      run($urandom_range(0, 20), sa, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    // Asynchronous reset in the middle of a run
    prog_len = 5'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (RC + 3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    pc_m = 0;
    idle0 = mk(1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    check_outs("async_rst", idle0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outs("rst_release", idle0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
